// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
//
// Round-robin scheduler that shares one fpu between NUM_REQ requesters.
// A requester offers an operation over valid/ready; the winner's operands are
// latched, the fpu start/cmd_end protocol is sequenced, and the result is
// returned to the issuing requester with a one-cycle rsp_valid pulse.
// Only one operation is ever in flight.
//
// Optional feature (compile-time macro FPU_ARB_TIMEOUT_EN):
//   WAIT_END watchdog. After TIMEOUT_CYC cycles without cmd_end the operation
//   is aborted with rsp_data = quiet NaN (32'h7FC00000) and rsp_err = 1.
//   Without the macro no counter exists and rsp_err is tied to 0.
//
// Ports:
//   clk          clock
//   arst         asynchronous reset, active low
//   req_valid    [NUM_REQ]     per-requester request valid
//   req_ready    [NUM_REQ]     per-requester accept (one-hot, IDLE only)
//   req_a/req_b  [NUM_REQ*32]  operands, slice i is [32*i +: 32]
//   req_op       [NUM_REQ*2]   operation code, slice i is [2*i +: 2]
//   rsp_valid    [NUM_REQ]     one-cycle pulse on the owner's bit
//   rsp_data     [32]          result, held until the next capture
//   rsp_id       [ID_W]        owner of rsp_data
//   rsp_err      1             watchdog abort flag (qualified by rsp_valid)
//   fpu_start/fpu_a/fpu_b/fpu_op   to the fpu
//   fpu_cmd_end/fpu_busy/fpu_result from the fpu
//   arb_busy     1             high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*2-1:0] req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic                 fpu_start,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic [1:0]           fpu_op,
    input  logic                 fpu_cmd_end,
    input  logic                 fpu_busy,
    input  logic [31:0]          fpu_result,
    output logic                 arb_busy
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Elaboration-time parameter sanity check
    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_param_err
        $error("fpu_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    state_e               state_q,     state_d;
    logic [ID_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]      owner_q,     owner_d;
    logic                 fpu_start_q, fpu_start_d;
    logic [31:0]          fpu_a_q,     fpu_a_d;
    logic [31:0]          fpu_b_q,     fpu_b_d;
    logic [1:0]           fpu_op_q,    fpu_op_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]      rsp_id_q,    rsp_id_d;

    logic [ID_W:0]        sum_s;
    logic [ID_W:0]        cand_s;
    logic [ID_W-1:0]      win_s;
    logic                 found_s;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 timeout_s;
`endif

    // Round-robin winner: first valid requester at or above rr_ptr, wrapping
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        sum_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s  = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            cand_s = (sum_s >= (ID_W+1)'(NUM_REQ)) ? (sum_s - (ID_W+1)'(NUM_REQ)) : sum_s;
            if (!found_s && req_valid[cand_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Ready is combinational and only ever offered in IDLE
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && found_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog counts WAIT_END cycles; it is zero whenever WAIT_END is entered
    always_comb begin
        wd_cnt_d  = (state_q == ST_WAIT_END) ? (wd_cnt_q + CNT_W'(1)) : '0;
        timeout_s = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
`endif

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        fpu_start_d = fpu_start_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
`ifdef FPU_ARB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    fpu_a_d  = req_a[32*win_s +: 32];
                    fpu_b_d  = req_b[32*win_s +: 32];
                    fpu_op_d = req_op[2*win_s +: 2];
                    owner_d  = win_s;
                    rr_ptr_d = (win_s == ID_W'(NUM_REQ - 1)) ? '0 : (win_s + ID_W'(1));
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A cmd_end still high from the previous op must clear first,
                // otherwise WAIT_END would take it for this op's completion.
                if (!fpu_busy && !fpu_cmd_end) begin
                    fpu_start_d = 1'b1;
                    state_d     = ST_WAIT_END;
                end else begin
                    state_d     = ST_ISSUE;
                end
            end
            ST_WAIT_END: begin
                if (fpu_cmd_end) begin
                    fpu_start_d          = 1'b0;
                    rsp_data_d           = fpu_result;
                    rsp_id_d             = owner_q;
                    rsp_valid_d[owner_q] = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
                    rsp_err_d            = 1'b0;
`endif
                    state_d              = ST_RESP;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (timeout_s) begin
                    fpu_start_d          = 1'b0;
                    rsp_data_d           = QNAN;
                    rsp_id_d             = owner_q;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    state_d              = ST_RESP;
                end
`endif
                else begin
                    state_d = ST_WAIT_END;
                end
            end
            ST_RESP: begin
                // rsp_valid falls back to its all-zero default here
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                fpu_start_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops fpu_start without a clock
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            fpu_start_q <= 1'b0;
            fpu_a_q     <= 32'h0000_0000;
            fpu_b_q     <= 32'h0000_0000;
            fpu_op_q    <= 2'b00;
            rsp_valid_q <= '0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            fpu_start_q <= fpu_start_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog counter and abort flag registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wd_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign fpu_start = fpu_start_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
//
// Self-checking bench for fpu_arbiter. A small fpu stand-in answers each start
// after a fixed latency. Each accepted request pushes its expected response to
// a scoreboard queue; every rsp_valid pulse pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TO_CYC  = 16;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef struct packed {
        logic [31:0]     a;
        logic [31:0]     b;
        logic [1:0]      op;
        logic [31:0]     exp;
        logic            err;
        logic [ID_W-1:0] id;
    } op_t;

    logic                  clk;
    logic                  arst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*2-1:0]  req_op;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_err;
    logic                  fpu_start;
    logic [31:0]           fpu_a;
    logic [31:0]           fpu_b;
    logic [1:0]            fpu_op;
    logic                  fpu_cmd_end;
    logic                  fpu_busy;
    logic [31:0]           fpu_result;
    logic                  arb_busy;

    // fpu stand-in state
    logic        m_busy;
    logic        m_cmd_end;
    logic        m_start_d;
    logic [31:0] m_res;
    int          m_cnt;
    logic        m_hang;
    logic        force_busy;
    logic        force_cmd;

    int   checks;
    int   errors;
    int   start_hi;
    op_t  pend [NUM_REQ][$];
    op_t  sb[$];
    int   grants[$];

    fpu_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err),
        .fpu_start   (fpu_start),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_op      (fpu_op),
        .fpu_cmd_end (fpu_cmd_end),
        .fpu_busy    (fpu_busy),
        .fpu_result  (fpu_result),
        .arb_busy    (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fpu_busy    = m_busy | force_busy;
    assign fpu_cmd_end = m_cmd_end | force_cmd;

    // Stand-in result: IEEE answers for the known vectors, otherwise a
    // scramble that makes every operand/op combination distinguishable.
    function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (op == OP_ADD && a == 32'h3f80_0000 && b == 32'h3f8c_cccd) return 32'h4006_6666;
        if (op == OP_MUL && a == 32'h3e80_0000 && b == 32'h3f00_0000) return 32'h3e00_0000;
        if (op == OP_ADD && a == 32'h4180_0000 && b == 32'h4200_0000) return 32'h4240_0000;
        if (op == OP_MUL && a == 32'h7f80_0000 && b == 32'h0000_0000) return 32'h7fc0_0000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                               input logic [31:0] exp, input logic err, input int id);
        op_t o;
        o.a = a; o.b = b; o.op = op; o.exp = exp; o.err = err; o.id = ID_W'(id);
        return o;
    endfunction

    function automatic op_t mk_scr(input int id, input int k);
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        a  = 32'h1000_0000 + 32'(id * 256 + k * 16 + 1);
        b  = 32'h00A5_0000 + 32'(k * 4096 + id);
        op = 2'(id + k);
        return mk(a, b, op, fpu_calc(a, b, op), 1'b0, id);
    endfunction

    // fpu stand-in: a rising start launches a 2-cycle op ending in a cmd_end pulse
    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            m_busy    <= 1'b0;
            m_cmd_end <= 1'b0;
            m_start_d <= 1'b0;
            m_res     <= 32'h0;
            m_cnt     <= 0;
            fpu_result <= 32'h0;
        end else begin
            m_start_d <= fpu_start;
            m_cmd_end <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy     <= 1'b0;
                    m_cmd_end  <= 1'b1;
                    fpu_result <= m_res;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (fpu_start && !m_start_d && !m_hang) begin
                m_busy <= 1'b1;
                m_cnt  <= 2;
                m_res  <= fpu_calc(fpu_a, fpu_b, fpu_op);
            end
        end
    end

    function automatic int pending_total();
        int n = 0;
        for (int i = 0; i < NUM_REQ; i++) n += pend[i].size();
        return n;
    endfunction

    // Compare one response pulse against the scoreboard head
    task automatic check_rsp();
        op_t e;
        if (rsp_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== (NUM_REQ'(1) << e.id)) begin
                    errors++;
                    $display("FAIL rsp_valid: got %b want one-hot bit %0d", rsp_valid, e.id);
                end
                checks++;
                if (rsp_id !== e.id) begin
                    errors++;
                    $display("FAIL rsp_id: got %0d want %0d", rsp_id, e.id);
                end
                checks++;
                if (rsp_data !== e.exp) begin
                    errors++;
                    $display("FAIL rsp_data: got %h want %h (id %0d)", rsp_data, e.exp, e.id);
                end
                checks++;
                if (rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
                end
            end
        end
    endtask

    // One clock: check responses, present pending requests, log handshakes
    task automatic step();
        logic [NUM_REQ-1:0] hs;
        op_t e;
        @(negedge clk);
        check_rsp();
        if (fpu_start === 1'b1) start_hi++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() > 0) begin
                e = pend[i][0];
                req_valid[i]       = 1'b1;
                req_a[32*i +: 32]  = e.a;
                req_b[32*i +: 32]  = e.b;
                req_op[2*i +: 2]   = e.op;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
        hs = req_valid & req_ready;
        if (hs != '0) begin
            checks++;
            if (!$onehot(hs)) begin
                errors++;
                $display("FAIL ready_onehot: handshake %b", hs);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) begin
                    e = pend[i].pop_front();
                    sb.push_back(e);
                    grants.push_back(i);
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending_total() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (pending_total() > 0 || sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d requests and %0d responses outstanding", pending_total(), sb.size());
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arst = 1'b0;
        req_valid = '0; force_busy = 1'b0; force_cmd = 1'b0; m_hang = 1'b0;
        sb.delete(); grants.delete();
        for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
        repeat (2) @(negedge clk);
        arst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (rsp_valid !== '0)  begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_id !== '0)     begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_err !== 1'b0)  begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL reset_fpu_start: got %b want 0", fpu_start); end
        checks++; if ({fpu_a, fpu_b, fpu_op} !== 66'h0) begin errors++; $display("FAIL reset_fpu_ops: got %h %h %h want 0", fpu_a, fpu_b, fpu_op); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy: got %b want 0", arb_busy); end
        checks++; if (req_ready !== '0)  begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        arst = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3f80_0000; req_b[31:0] = 32'h3f8c_cccd; req_op[1:0] = OP_ADD;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        sb.push_back(mk(32'h3f80_0000, 32'h3f8c_cccd, OP_ADD, 32'h4006_6666, 1'b0, 0));
        @(negedge clk);
        req_valid = '0;
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL single_issue_start: got %b want 0", fpu_start); end
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", arb_busy); end
        checks++; if (fpu_a !== 32'h3f80_0000 || fpu_b !== 32'h3f8c_cccd || fpu_op !== OP_ADD) begin
            errors++; $display("FAIL single_operands: got %h %h %0d want 3f800000 3f8ccccd 0", fpu_a, fpu_b, fpu_op);
        end
        @(negedge clk);
        checks++; if (fpu_start !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b want 1", fpu_start); end
        drain(100);
    endtask

    task automatic test_two_same_cycle();
        apply_reset();
        pend[1].push_back(mk(32'h3e80_0000, 32'h3f00_0000, OP_MUL, 32'h3e00_0000, 1'b0, 1));
        pend[2].push_back(mk(32'h4180_0000, 32'h4200_0000, OP_ADD, 32'h4240_0000, 1'b0, 2));
        drain(200);
        checks++;
        if (grants.size() != 2 || grants[0] != 1 || grants[1] != 2) begin
            errors++; $display("FAIL two_order: got %p want '{1, 2}", grants);
        end
        // rr_ptr should now be 3, so an all-valid burst starts at 3
        grants.delete();
        for (int i = 0; i < NUM_REQ; i++) pend[i].push_back(mk_scr(i, 0));
        drain(300);
        checks++;
        if (grants.size() != 4 || grants[0] != 3 || grants[1] != 0 || grants[2] != 1 || grants[3] != 2) begin
            errors++; $display("FAIL rr_ptr_after_two: got %p want '{3, 0, 1, 2}", grants);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NUM_REQ; i++) pend[i].push_back(mk_scr(i, k + 1));
        drain(500);
        checks++;
        if (grants.size() != 8) begin
            errors++; $display("FAIL fair_count: got %0d want 8", grants.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (grants[j] != j % NUM_REQ) begin
                    errors++; $display("FAIL fair_order: grant %0d got %0d want %0d", j, grants[j], j % NUM_REQ);
                end
            end
        end
    endtask

    task automatic test_issue_hold();
        grants.delete();
        start_hi   = 0;
        force_busy = 1'b1;
        pend[2].push_back(mk_scr(2, 7));
        repeat (5) step();
        checks++; if (start_hi != 0 || arb_busy !== 1'b1) begin
            errors++; $display("FAIL hold_busy: start cycles %0d busy %b want 0 and 1", start_hi, arb_busy);
        end
        force_busy = 1'b0;
        force_cmd  = 1'b1;
        repeat (3) step();
        checks++; if (start_hi != 0) begin
            errors++; $display("FAIL hold_stale_cmd_end: start cycles %0d want 0", start_hi);
        end
        force_cmd = 1'b0;
        drain(100);
        checks++; if (start_hi == 0) begin
            errors++; $display("FAIL hold_release: start never asserted");
        end
    endtask

    task automatic test_nan();
        pend[3].push_back(mk(32'h7f80_0000, 32'h0000_0000, OP_MUL, 32'h7fc0_0000, 1'b0, 3));
        drain(100);
        repeat (3) step();
        checks++; if (rsp_data[30:23] !== 8'hff || rsp_data[22:0] == 23'h0) begin
            errors++; $display("FAIL nan_format: got %h want exponent ff and nonzero mantissa", rsp_data);
        end
        checks++; if (rsp_data !== 32'h7fc0_0000) begin
            errors++; $display("FAIL nan_hold: got %h want 7fc00000", rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        m_hang = 1'b1;
        pend[0].push_back(mk_scr(0, 9));
        while (fpu_start !== 1'b1 && n < 30) begin
            step();
            #1;
            n++;
        end
        checks++; if (fpu_start !== 1'b1) begin errors++; $display("FAIL rmid_reach_wait: fpu_start %b want 1", fpu_start); end
        @(negedge clk);
        #2;
        arst = 1'b0;
        #1;
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL rmid_start_async: got %b want 0", fpu_start); end
        checks++; if (arb_busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy_async: got %b want 0", arb_busy); end
        sb.delete(); grants.delete(); req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rmid_no_rsp: got %b want 0", rsp_valid); end
        end
        arst   = 1'b1;
        m_hang = 1'b0;
        pend[1].push_back(mk_scr(1, 5));
        drain(100);
        checks++; if (grants.size() != 1 || grants[0] != 1) begin
            errors++; $display("FAIL rmid_after: got %p want '{1}", grants);
        end
    endtask

`ifdef FPU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        grants.delete();
        start_hi = 0;
        m_hang   = 1'b1;
        pend[2].push_back(mk(32'h4000_0000, 32'h4040_0000, OP_DIV, 32'h7fc0_0000, 1'b1, 2));
        drain(100);
        checks++; if (start_hi != TO_CYC) begin
            errors++; $display("FAIL timeout_cycles: got %0d want %0d", start_hi, TO_CYC);
        end
        m_hang = 1'b0;
        pend[3].push_back(mk_scr(3, 6));
        drain(100);
        checks++; if (grants.size() != 2 || grants[1] != 3) begin
            errors++; $display("FAIL timeout_next: got %p want '{2, 3}", grants);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        checks = 0; errors = 0; start_hi = 0;
        arst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        m_hang = 1'b0; force_busy = 1'b0; force_cmd = 1'b0;
        test_reset();
        test_single_add();
        test_two_same_cycle();
        test_fairness();
        test_issue_hold();
        test_nan();
        test_reset_mid();
`ifdef FPU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
